// File: rtl/cpu_types_pkg.sv
// Shared RV32I control-unit types: decoded operation classes, ALU ops, immediate formats, opcodes.
package cpu_types_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 20;

    typedef enum logic [5:0] {
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU,
        CU_BGEU, CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SH, CU_SW, CU_ADDI, CU_SLTI, CU_SLTIU,
        CU_XORI, CU_ORI, CU_ANDI, CU_SLLI, CU_SRLI, CU_SRAI, CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU,
        CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND, CU_ERROR
    } cuOPType;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluOPType;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_U, IMM_J, IMM_I, IMM_S, IMM_B, IMM_SH
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        cuOPType            cu_op;
        logic [REG_W-1:0]   reg_1;
        logic [REG_W-1:0]   reg_2;
        logic [REG_W-1:0]   rd;
        logic [IMM_W-1:0]   imm;
        aluOPType           alu_op;
        logic               reg_write;
        logic               mem_write;
        logic               mem_read;
        logic               alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        cu_op:     CU_ERROR,
        reg_1:     5'd0,
        reg_2:     5'd0,
        rd:        5'd0,
        imm:       20'd0,
        alu_op:    ALU_ADD,
        reg_write: 1'b0,
        mem_write: 1'b0,
        mem_read:  1'b0,
        alu_src:   1'b0
    };

endpackage

// File: rtl/rv32i_controller_imm_gen.sv
// Combinational immediate extraction; the format is chosen by the decoder.
module imm_gen
    import cpu_types_pkg::*;
(
    input  logic [31:7]      instr_i,
    input  imm_fmt_e         fmt_i,
    output logic [IMM_W-1:0] imm_o
);

    // J and B immediates are kept as offset>>1, matching the 20-bit datapath field.
    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_U:   imm_o = instr_i[31:12];
            IMM_J:   imm_o = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};
            IMM_I:   imm_o = {{8{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{8{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{8{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
            IMM_SH:  imm_o = {15'd0, instr_i[24:20]};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_controller.sv
// RV32I control unit: decodes one instruction per cycle into registered datapath controls.
module rv32i_controller
    import cpu_types_pkg::*;
(
    input  logic               clk,
    input  logic               nRst,
    input  logic [INSTR_W-1:0] instruction,
    output cuOPType            cuOP,
    output logic [REG_W-1:0]   reg_1,
    output logic [REG_W-1:0]   reg_2,
    output logic [REG_W-1:0]   rd,
    output logic [IMM_W-1:0]   imm,
    output aluOPType           aluOP,
    output logic               regWrite,
    output logic               memWrite,
    output logic               memRead,
    output logic               aluSrc
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    ctrl_t            dec_c;
    imm_fmt_e         fmt_c;
    logic [IMM_W-1:0] imm_c;
    ctrl_t            ctrl_d;
    ctrl_t            ctrl_q;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    // First pass picks the operation; second pass fills fields only for legal encodings.
    always_comb begin
        dec_c = CTRL_RESET;
        fmt_c = IMM_NONE;
        if (instruction[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI:   begin dec_c.cu_op = CU_LUI;   fmt_c = IMM_U; end
                OPC_AUIPC: begin dec_c.cu_op = CU_AUIPC; fmt_c = IMM_U; end
                OPC_JAL:   begin dec_c.cu_op = CU_JAL;   fmt_c = IMM_J; end
                OPC_JALR: begin
                    if (funct3 == 3'b000) dec_c.cu_op = CU_JALR;
                    fmt_c = IMM_I;
                end
                OPC_BRANCH: begin
                    fmt_c = IMM_B;
                    case (funct3)
                        3'b000:  begin dec_c.cu_op = CU_BEQ;  dec_c.alu_op = ALU_SUB;  end
                        3'b001:  begin dec_c.cu_op = CU_BNE;  dec_c.alu_op = ALU_SUB;  end
                        3'b100:  begin dec_c.cu_op = CU_BLT;  dec_c.alu_op = ALU_SLT;  end
                        3'b101:  begin dec_c.cu_op = CU_BGE;  dec_c.alu_op = ALU_SLT;  end
                        3'b110:  begin dec_c.cu_op = CU_BLTU; dec_c.alu_op = ALU_SLTU; end
                        3'b111:  begin dec_c.cu_op = CU_BGEU; dec_c.alu_op = ALU_SLTU; end
                        default: ;
                    endcase
                end
                OPC_LOAD: begin
                    fmt_c = IMM_I;
                    case (funct3)
                        3'b000:  dec_c.cu_op = CU_LB;
                        3'b001:  dec_c.cu_op = CU_LH;
                        3'b010:  dec_c.cu_op = CU_LW;
                        3'b100:  dec_c.cu_op = CU_LBU;
                        3'b101:  dec_c.cu_op = CU_LHU;
                        default: ;
                    endcase
                end
                OPC_STORE: begin
                    fmt_c = IMM_S;
                    case (funct3)
                        3'b000:  dec_c.cu_op = CU_SB;
                        3'b001:  dec_c.cu_op = CU_SH;
                        3'b010:  dec_c.cu_op = CU_SW;
                        default: ;
                    endcase
                end
                OPC_OPIMM: begin
                    fmt_c = IMM_I;
                    case (funct3)
                        3'b000: begin dec_c.cu_op = CU_ADDI;  dec_c.alu_op = ALU_ADD;  end
                        3'b010: begin dec_c.cu_op = CU_SLTI;  dec_c.alu_op = ALU_SLT;  end
                        3'b011: begin dec_c.cu_op = CU_SLTIU; dec_c.alu_op = ALU_SLTU; end
                        3'b100: begin dec_c.cu_op = CU_XORI;  dec_c.alu_op = ALU_XOR;  end
                        3'b110: begin dec_c.cu_op = CU_ORI;   dec_c.alu_op = ALU_OR;   end
                        3'b111: begin dec_c.cu_op = CU_ANDI;  dec_c.alu_op = ALU_AND;  end
                        3'b001: begin
                            fmt_c = IMM_SH;
                            if (funct7 == F7_BASE) begin
                                dec_c.cu_op  = CU_SLLI;
                                dec_c.alu_op = ALU_SLL;
                            end
                        end
                        default: begin
                            fmt_c = IMM_SH;
                            if (funct7 == F7_BASE) begin
                                dec_c.cu_op  = CU_SRLI;
                                dec_c.alu_op = ALU_SRL;
                            end else if (funct7 == F7_ALT) begin
                                dec_c.cu_op  = CU_SRAI;
                                dec_c.alu_op = ALU_SRA;
                            end
                        end
                    endcase
                end
                OPC_OP: begin
                    case ({funct7, funct3})
                        {F7_BASE, 3'b000}: begin dec_c.cu_op = CU_ADD;  dec_c.alu_op = ALU_ADD;  end
                        {F7_ALT,  3'b000}: begin dec_c.cu_op = CU_SUB;  dec_c.alu_op = ALU_SUB;  end
                        {F7_BASE, 3'b001}: begin dec_c.cu_op = CU_SLL;  dec_c.alu_op = ALU_SLL;  end
                        {F7_BASE, 3'b010}: begin dec_c.cu_op = CU_SLT;  dec_c.alu_op = ALU_SLT;  end
                        {F7_BASE, 3'b011}: begin dec_c.cu_op = CU_SLTU; dec_c.alu_op = ALU_SLTU; end
                        {F7_BASE, 3'b100}: begin dec_c.cu_op = CU_XOR;  dec_c.alu_op = ALU_XOR;  end
                        {F7_BASE, 3'b101}: begin dec_c.cu_op = CU_SRL;  dec_c.alu_op = ALU_SRL;  end
                        {F7_ALT,  3'b101}: begin dec_c.cu_op = CU_SRA;  dec_c.alu_op = ALU_SRA;  end
                        {F7_BASE, 3'b110}: begin dec_c.cu_op = CU_OR;   dec_c.alu_op = ALU_OR;   end
                        {F7_BASE, 3'b111}: begin dec_c.cu_op = CU_AND;  dec_c.alu_op = ALU_AND;  end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        if (dec_c.cu_op == CU_ERROR) begin
            dec_c = CTRL_RESET;
            fmt_c = IMM_NONE;
        end else begin
            case (opcode)
                OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                    dec_c.rd        = instruction[11:7];
                    dec_c.reg_write = 1'b1;
                    dec_c.alu_src   = 1'b1;
                end
                OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                    dec_c.reg_1     = instruction[19:15];
                    dec_c.rd        = instruction[11:7];
                    dec_c.reg_write = 1'b1;
                    dec_c.alu_src   = 1'b1;
                    dec_c.mem_read  = (opcode == OPC_LOAD);
                end
                OPC_STORE: begin
                    dec_c.reg_1     = instruction[19:15];
                    dec_c.reg_2     = instruction[24:20];
                    dec_c.mem_write = 1'b1;
                    dec_c.alu_src   = 1'b1;
                end
                OPC_BRANCH: begin
                    dec_c.reg_1     = instruction[19:15];
                    dec_c.reg_2     = instruction[24:20];
                end
                default: begin
                    dec_c.reg_1     = instruction[19:15];
                    dec_c.reg_2     = instruction[24:20];
                    dec_c.rd        = instruction[11:7];
                    dec_c.reg_write = 1'b1;
                end
            endcase
        end
    end

    imm_gen u_imm_gen (
        .instr_i (instruction[31:7]),
        .fmt_i   (fmt_c),
        .imm_o   (imm_c)
    );

    always_comb begin
        ctrl_d     = dec_c;
        ctrl_d.imm = imm_c;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) ctrl_q <= CTRL_RESET;
        else       ctrl_q <= ctrl_d;
    end

    assign cuOP     = ctrl_q.cu_op;
    assign reg_1    = ctrl_q.reg_1;
    assign reg_2    = ctrl_q.reg_2;
    assign rd       = ctrl_q.rd;
    assign imm      = ctrl_q.imm;
    assign aluOP    = ctrl_q.alu_op;
    assign regWrite = ctrl_q.reg_write;
    assign memWrite = ctrl_q.mem_write;
    assign memRead  = ctrl_q.mem_read;
    assign aluSrc   = ctrl_q.alu_src;

endmodule

// File: tb/tb_rv32i_controller.sv
// Directed bench for rv32i_controller: hand-decoded instruction words checked one edge after apply.
module tb_rv32i_controller;
    import cpu_types_pkg::*;

    logic        clk = 1'b0;
    logic        nRst = 1'b1;
    logic [31:0] instruction = 32'd0;
    cuOPType     cuOP;
    logic [4:0]  reg_1, reg_2, rd;
    logic [19:0] imm;
    aluOPType    aluOP;
    logic        regWrite, memWrite, memRead, aluSrc;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_controller dut (
        .clk         (clk),
        .nRst        (nRst),
        .instruction (instruction),
        .cuOP        (cuOP),
        .reg_1       (reg_1),
        .reg_2       (reg_2),
        .rd          (rd),
        .imm         (imm),
        .aluOP       (aluOP),
        .regWrite    (regWrite),
        .memWrite    (memWrite),
        .memRead     (memRead),
        .aluSrc      (aluSrc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input cuOPType e_cu, input logic [4:0] e_r1,
                             input logic [4:0] e_r2, input logic [4:0] e_rd, input logic [19:0] e_imm,
                             input aluOPType e_alu, input logic e_rw, input logic e_mw,
                             input logic e_mr, input logic e_as);
        check({tag, ".cuOP"},     32'(cuOP),     32'(e_cu));
        check({tag, ".reg_1"},    32'(reg_1),    32'(e_r1));
        check({tag, ".reg_2"},    32'(reg_2),    32'(e_r2));
        check({tag, ".rd"},       32'(rd),       32'(e_rd));
        check({tag, ".imm"},      32'(imm),      32'(e_imm));
        check({tag, ".aluOP"},    32'(aluOP),    32'(e_alu));
        check({tag, ".regWrite"}, 32'(regWrite), 32'(e_rw));
        check({tag, ".memWrite"}, 32'(memWrite), 32'(e_mw));
        check({tag, ".memRead"},  32'(memRead),  32'(e_mr));
        check({tag, ".aluSrc"},   32'(aluSrc),   32'(e_as));
    endtask

    // Drive on the falling edge, sample just after the following rising edge.
    task automatic apply(input logic [31:0] word);
        @(negedge clk);
        instruction = word;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_error(input string tag, input logic [31:0] word);
        apply(word);
        check_all(tag, CU_ERROR, 5'd0, 5'd0, 5'd0, 20'h0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        instruction = 32'hAAAAA537;
        #1 nRst = 1'b0;
        #2;
        check_all("reset", CU_ERROR, 5'd0, 5'd0, 5'd0, 20'h0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all("reset_held", CU_ERROR, 5'd0, 5'd0, 5'd0, 20'h0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nRst = 1'b1;

        apply(32'hAAAAA537);
        check_all("lui",   CU_LUI,   5'd0,  5'd0,  5'd10, 20'hAAAAA, ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b1);
        apply(32'hABC50D13);
        check_all("addi",  CU_ADDI,  5'd10, 5'd0,  5'd26, 20'hFFABC, ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b1);
        apply(32'h00C50C33);
        check_all("add",   CU_ADD,   5'd10, 5'd12, 5'd24, 20'h0,     ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b0);
        apply(32'h40C50C33);
        check_all("sub",   CU_SUB,   5'd10, 5'd12, 5'd24, 20'h0,     ALU_SUB,  1'b1, 1'b0, 1'b0, 1'b0);
        apply(32'hEEAC2723);
        check_all("sw",    CU_SW,    5'd24, 5'd10, 5'd0,  20'hFFEEE, ALU_ADD,  1'b0, 1'b1, 1'b0, 1'b1);
        apply(32'h6EDA88E7);
        check_all("jalr",  CU_JALR,  5'd21, 5'd0,  5'd17, 20'h006ED, ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b1);
        expect_error("jalr_f3", 32'h6EDA98E7);
        expect_error("all_ones", 32'hFFFFFFFF);
        apply(32'h7FE000EF);
        check_all("jal",   CU_JAL,   5'd0,  5'd0,  5'd1,  20'h003FF, ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b1);
        apply(32'h8020C863);
        check_all("blt",   CU_BLT,   5'd1,  5'd2,  5'd0,  20'hFF808, ALU_SLT,  1'b0, 1'b0, 1'b0, 1'b0);
        apply(32'hFFF1C283);
        check_all("lbu",   CU_LBU,   5'd3,  5'd0,  5'd5,  20'hFFFFF, ALU_ADD,  1'b1, 1'b0, 1'b1, 1'b1);
        apply(32'h41F35393);
        check_all("srai",  CU_SRAI,  5'd6,  5'd0,  5'd7,  20'h0001F, ALU_SRA,  1'b1, 1'b0, 1'b0, 1'b1);
        expect_error("slli_f7", 32'h41F31393);
        expect_error("load_f3", 32'hFFF1B283);
        apply(32'h12345297);
        check_all("auipc", CU_AUIPC, 5'd0,  5'd0,  5'd5,  20'h12345, ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b1);
        expect_error("or_f7", 32'h02C56C33);
        apply(32'h00C53C33);
        check_all("sltu",  CU_SLTU,  5'd10, 5'd12, 5'd24, 20'h0,     ALU_SLTU, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_error("low_bits", 32'hAAAAA534);

        // Asynchronous reset between edges must clear outputs without waiting for clk.
        apply(32'hAAAAA537);
        check_all("lui2",  CU_LUI,   5'd0,  5'd0,  5'd10, 20'hAAAAA, ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b1);
        #2 nRst = 1'b0;
        #1;
        check_all("async_rst", CU_ERROR, 5'd0, 5'd0, 5'd0, 20'h0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        apply(32'hEEAC2723);
        check_all("sw_after_rst", CU_SW, 5'd24, 5'd10, 5'd0, 20'hFFEEE, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
